// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types for the single-port RAM arbiter. Requester IDs
//                and the in-flight tag that rides the two pipeline stages
//                between ISSUE and RET.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Requester identifiers carried in the tag
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_VDP = 1'b1;

    // One in-flight access: valid slot, who owns it, and whether it writes
    typedef struct packed {
        logic valid;
        logic id;
        logic we;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one single-port synchronous RAM between the 65C02 CPU
//                bus and the VDP fetch port. One access per clk reaches the
//                RAM; the VDP has priority, and a starvation counter forces a
//                CPU win after STARVE_MAX consecutive lost arbitrations.
//                Fixed 3-stage pipeline: ISSUE -> RAM -> RET, ack registered
//                two edges after the issuing edge.
//  Ports       : clk, reset                  - system clock, sync active-high reset
//                cpu_req/we/addr/wdata       - CPU request (level, held to ack)
//                cpu_ack, cpu_rdata          - CPU completion pulse / read data
//                vdp_req/addr                - VDP read request (level, held to ack)
//                vdp_ack, vdp_rdata          - VDP completion pulse / read data
//                ram_addr/wdata/we, ram_rdata - registered RAM interface
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vdp_req,
    input  logic [ADDR_W-1:0] vdp_addr,
    output logic              vdp_ack,
    output logic [DATA_W-1:0] vdp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);
    import ram_arb_pkg::*;

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    // r_tag1: issued on the previous edge (RAM stage)
    // r_tag2: issued two edges ago; its read data is on ram_rdata now
    tag_t r_tag1;
    tag_t r_tag2;
    tag_t w_tag_nxt;

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_STARVE_W-1:0] w_starve_nxt;

    logic w_cpu_busy;
    logic w_vdp_busy;
    logic w_cpu_elig;
    logic w_vdp_elig;
    logic w_starve_hit;
    logic w_cpu_win;
    logic w_vdp_win;
    logic w_ret_cpu;
    logic w_ret_vdp;

    // A requester with an access in either pipeline stage sits out, which
    // gives each side at most one access in flight.
    assign w_cpu_busy = (r_tag1.valid && (r_tag1.id == REQ_CPU)) ||
                        (r_tag2.valid && (r_tag2.id == REQ_CPU));
    assign w_vdp_busy = (r_tag1.valid && (r_tag1.id == REQ_VDP)) ||
                        (r_tag2.valid && (r_tag2.id == REQ_VDP));

    assign w_cpu_elig   = cpu_req && !w_cpu_busy;
    assign w_vdp_elig   = vdp_req && !w_vdp_busy;
    assign w_starve_hit = (r_starve_cnt == c_STARVE_W'(STARVE_MAX));

    assign w_ret_cpu = r_tag2.valid && (r_tag2.id == REQ_CPU);
    assign w_ret_vdp = r_tag2.valid && (r_tag2.id == REQ_VDP);

    // Arbitration and starvation bookkeeping
    always_comb begin
        w_cpu_win    = 1'b0;
        w_vdp_win    = 1'b0;
        w_starve_nxt = r_starve_cnt;
        w_tag_nxt    = '0;

        // VDP wins ties unless the CPU has been passed over STARVE_MAX times
        w_cpu_win = w_cpu_elig && (!w_vdp_elig || w_starve_hit);
        w_vdp_win = w_vdp_elig && !w_cpu_win;

        if (!cpu_req || w_cpu_win) begin
            w_starve_nxt = '0;
        end else if (w_vdp_win && w_cpu_elig && !w_starve_hit) begin
            w_starve_nxt = r_starve_cnt + c_STARVE_W'(1);
        end

        w_tag_nxt.valid = w_cpu_win || w_vdp_win;
        w_tag_nxt.id    = w_vdp_win ? REQ_VDP : REQ_CPU;
        w_tag_nxt.we    = w_cpu_win && cpu_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag1       <= '0;
            r_tag2       <= '0;
            r_starve_cnt <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_we       <= 1'b0;
            cpu_ack      <= 1'b0;
            vdp_ack      <= 1'b0;
            cpu_rdata    <= '0;
            vdp_rdata    <= '0;
        end else begin
            r_tag1       <= w_tag_nxt;
            r_tag2       <= r_tag1;
            r_starve_cnt <= w_starve_nxt;

            // ISSUE: the winner drives the RAM; with no winner the address
            // and write data simply hold
            ram_we <= w_cpu_win && cpu_we;
            if (w_cpu_win) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end else if (w_vdp_win) begin
                ram_addr  <= vdp_addr;
            end

            // RET: acknowledge and capture read data for the stage-2 owner
            cpu_ack <= w_ret_cpu;
            vdp_ack <= w_ret_vdp;
            if (w_ret_cpu && !r_tag2.we) begin
                cpu_rdata <= ram_rdata;
            end
            if (w_ret_vdp) begin
                vdp_rdata <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. A behavioural RAM device
//                sits on the ram_* port; an access-level model tracks, per
//                requester, the edge of its last issue and the edge its ack is
//                due, plus a byte array holding the expected RAM contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vdp_req;
    logic [ADDR_W-1:0] vdp_addr;
    logic              vdp_ack;
    logic [DATA_W-1:0] vdp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .vdp_req  (vdp_req),
        .vdp_addr (vdp_addr),
        .vdp_ack  (vdp_ack),
        .vdp_rdata(vdp_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    // Single-port synchronous RAM device, read-first
    logic [DATA_W-1:0] dev_mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) dev_mem[ram_addr] <= ram_wdata;
        ram_rdata <= dev_mem[ram_addr];
    end

    // ------------------------------------------------------------------
    // Access-level reference model
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] model_mem [0:65535];
    int                edge_n;
    int                cpu_last, vdp_last;      // edge of last issue
    int                cpu_ack_at, vdp_ack_at;  // edge whose output carries the ack
    int                starve_m;
    logic              cpu_pend_we;
    logic [DATA_W-1:0] cpu_pend_data, vdp_pend_data;
    logic              exp_cpu_ack, exp_vdp_ack, exp_ram_we;
    logic [DATA_W-1:0] exp_cpu_rdata, exp_vdp_rdata, exp_ram_wdata;
    logic [ADDR_W-1:0] exp_ram_addr;

    // Predicts what the next clock edge will do from the current inputs
    task automatic model_step();
        int e;
        bit ce, ve, cw, vw;
        e = edge_n + 1;
        exp_cpu_ack = 1'b0;
        exp_vdp_ack = 1'b0;
        exp_ram_we  = 1'b0;
        if (reset) begin
            cpu_last      = -100;
            vdp_last      = -100;
            cpu_ack_at    = -1;
            vdp_ack_at    = -1;
            starve_m      = 0;
            exp_cpu_rdata = '0;
            exp_vdp_rdata = '0;
            exp_ram_wdata = '0;
            exp_ram_addr  = '0;
        end else begin
            if (cpu_ack_at == e) begin
                exp_cpu_ack = 1'b1;
                if (!cpu_pend_we) exp_cpu_rdata = cpu_pend_data;
                cpu_ack_at = -1;
            end
            if (vdp_ack_at == e) begin
                exp_vdp_ack   = 1'b1;
                exp_vdp_rdata = vdp_pend_data;
                vdp_ack_at    = -1;
            end
            // Each requester may issue once every three edges
            ce = cpu_req && (e - cpu_last >= 3);
            ve = vdp_req && (e - vdp_last >= 3);
            cw = ce && (!ve || starve_m == STARVE_MAX);
            vw = ve && !cw;
            if (!cpu_req || cw) starve_m = 0;
            else if (vw && ce && starve_m < STARVE_MAX) starve_m++;
            if (cw) begin
                cpu_last      = e;
                cpu_ack_at    = e + 2;
                cpu_pend_we   = cpu_we;
                exp_ram_addr  = cpu_addr;
                exp_ram_wdata = cpu_wdata;
                if (cpu_we) begin
                    model_mem[cpu_addr] = cpu_wdata;
                    exp_ram_we = 1'b1;
                end else begin
                    cpu_pend_data = model_mem[cpu_addr];
                end
            end
            if (vw) begin
                vdp_last      = e;
                vdp_ack_at    = e + 2;
                exp_ram_addr  = vdp_addr;
                vdp_pend_data = model_mem[vdp_addr];
            end
        end
    endtask

    // Advance one clock; outputs are sampled afterwards on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        case ($urandom_range(0, 3))
            0, 1:    a = 16'h0200 + 16'($urandom_range(0, 15));
            2:       a = 16'($urandom);
            default: a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
        endcase
        return a;
    endfunction

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = 8'($urandom);
    endtask

    task automatic new_vdp();
        vdp_req  = 1'b1;
        vdp_addr = rand_addr();
    endtask

    // Requesters hold until their (model-predicted) ack, then renew or drop
    task automatic drive_reqs(input int p_start, input int p_new);
        if (exp_cpu_ack) begin
            if (int'($urandom_range(0, 99)) < p_new) new_cpu(); else cpu_req = 1'b0;
        end else if (!cpu_req && int'($urandom_range(0, 99)) < p_start) begin
            new_cpu();
        end
        if (exp_vdp_ack) begin
            if (int'($urandom_range(0, 99)) < p_new) new_vdp(); else vdp_req = 1'b0;
        end else if (!vdp_req && int'($urandom_range(0, 99)) < p_start) begin
            new_vdp();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_reqs(0, 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) tick();
        checks++;
        if ({cpu_ack, vdp_ack, ram_we} !== 3'b000 || ram_addr !== '0 || ram_wdata !== '0 ||
            cpu_rdata !== '0 || vdp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b%b we=%b addr=%h wdata=%h crd=%h vrd=%h, required all 0",
                     cpu_ack, vdp_ack, ram_we, ram_addr, ram_wdata, cpu_rdata, vdp_rdata);
        end
        reset = 1'b0;
        new_cpu();
        new_vdp();
        for (int i = 0; i < 13; i++) begin
            tick();
            drive_reqs(100, 100);
        end
        // Reset mid-traffic for two cycles
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cpu_ack, vdp_ack, ram_we} !== 3'b000 || ram_addr !== '0 || ram_wdata !== '0 ||
                cpu_rdata !== '0 || vdp_rdata !== '0) begin
                errors++;
                $display("FAIL midreset_outputs[%0d]: ack=%b%b we=%b addr=%h wdata=%h crd=%h vrd=%h, required all 0",
                         i, cpu_ack, vdp_ack, ram_we, ram_addr, ram_wdata, cpu_rdata, vdp_rdata);
            end
        end
        reset   = 1'b0;
        cpu_req = 1'b0;
        vdp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({cpu_ack, vdp_ack, ram_we} !== 3'b000) begin
                errors++;
                $display("FAIL dropped_tags[%0d]: cpu_ack=%b vdp_ack=%b ram_we=%b, required 0 0 0",
                         i, cpu_ack, vdp_ack, ram_we);
            end
        end
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0200 || ram_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL write_issue: we=%b addr=%h wdata=%h, required 1 0200 5a", ram_we, ram_addr, ram_wdata);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse: we=%b ack=%b, required 0 0", ram_we, cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL write_ack: cpu_ack=%b, required 1", cpu_ack);
        end
        cpu_we = 1'b0;      // new request: read back the same location
        tick();
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 16'h0200 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: we=%b addr=%h ack=%b, required 0 0200 0", ram_we, ram_addr, cpu_ack);
        end
        tick();
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL read_back: ack=%b rdata=%h, required 1 5a", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL ack_pulse_hold: ack=%b rdata=%h, required 0 5a", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_vdp_only();
        logic [DATA_W-1:0] exp;
        for (int n = 0; n < 6; n++) begin
            vdp_req  = 1'b1;
            vdp_addr = (n == 0) ? 16'hFFFF : rand_addr();
            exp      = model_mem[vdp_addr];
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (vdp_ack !== (c == 2)) begin
                    errors++;
                    $display("FAIL vdp_cadence[%0d.%0d]: vdp_ack=%b, required %0d", n, c, vdp_ack, (c == 2));
                end
            end
            checks++;
            if (vdp_rdata !== exp) begin
                errors++;
                $display("FAIL vdp_data[%0d] @%h: got %h, required %h", n, vdp_addr, vdp_rdata, exp);
            end
        end
        vdp_req = 1'b0;
        drain();
    endtask

    task automatic test_contention();
        int run, max_run, cpu_acks;
        run = 0; max_run = 0; cpu_acks = 0;
        new_cpu();
        new_vdp();
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (cpu_ack !== exp_cpu_ack || vdp_ack !== exp_vdp_ack) begin
                errors++;
                $display("FAIL contend_ack[%0d]: cpu/vdp ack=%b%b, required %b%b",
                         i, cpu_ack, vdp_ack, exp_cpu_ack, exp_vdp_ack);
            end
            checks++;
            if (cpu_rdata !== exp_cpu_rdata || vdp_rdata !== exp_vdp_rdata) begin
                errors++;
                $display("FAIL contend_data[%0d]: cpu=%h vdp=%h, required %h %h",
                         i, cpu_rdata, vdp_rdata, exp_cpu_rdata, exp_vdp_rdata);
            end
            if (cpu_ack) begin
                cpu_acks++;
                run = 0;
            end else if (vdp_ack) begin
                run++;
                if (run > max_run) max_run = run;
            end
            drive_reqs(100, 100);
        end
        checks++;
        if (max_run > STARVE_MAX || cpu_acks < 60 / (3 * (STARVE_MAX + 1))) begin
            errors++;
            $display("FAIL starvation: max VDP run %0d, cpu acks %0d, required run<=%0d acks>=%0d",
                     max_run, cpu_acks, STARVE_MAX, 60 / (3 * (STARVE_MAX + 1)));
        end
        drain();
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] exp_c, exp_v;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFF;
        vdp_req = 1'b1; vdp_addr = 16'h0000;
        exp_c = model_mem[16'hFFFF];
        exp_v = model_mem[16'h0000];
        tick();
        checks++;
        if (ram_addr !== 16'h0000 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL simul_first: ram_addr=%h we=%b, required 0000 0 (VDP first)", ram_addr, ram_we);
        end
        tick();
        checks++;
        if (ram_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL simul_second: ram_addr=%h, required ffff (CPU next)", ram_addr);
        end
        tick();
        checks++;
        if (vdp_ack !== 1'b1 || cpu_ack !== 1'b0 || vdp_rdata !== exp_v) begin
            errors++;
            $display("FAIL simul_vdp_ack: ack=%b%b rdata=%h, required cpu0 vdp1 %h", cpu_ack, vdp_ack, vdp_rdata, exp_v);
        end
        vdp_req = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || vdp_ack !== 1'b0 || cpu_rdata !== exp_c) begin
            errors++;
            $display("FAIL simul_cpu_ack: ack=%b%b rdata=%h, required cpu1 vdp0 %h", cpu_ack, vdp_ack, cpu_rdata, exp_c);
        end
        cpu_req = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            tick();
            checks++;
            if (cpu_ack !== exp_cpu_ack) begin
                errors++;
                $display("FAIL rnd_cpu_ack @%0d: got %b required %b", edge_n, cpu_ack, exp_cpu_ack);
            end
            checks++;
            if (vdp_ack !== exp_vdp_ack) begin
                errors++;
                $display("FAIL rnd_vdp_ack @%0d: got %b required %b", edge_n, vdp_ack, exp_vdp_ack);
            end
            checks++;
            if (cpu_rdata !== exp_cpu_rdata) begin
                errors++;
                $display("FAIL rnd_cpu_rdata @%0d: got %h required %h", edge_n, cpu_rdata, exp_cpu_rdata);
            end
            checks++;
            if (vdp_rdata !== exp_vdp_rdata) begin
                errors++;
                $display("FAIL rnd_vdp_rdata @%0d: got %h required %h", edge_n, vdp_rdata, exp_vdp_rdata);
            end
            checks++;
            if (ram_we !== exp_ram_we) begin
                errors++;
                $display("FAIL rnd_ram_we @%0d: got %b required %b", edge_n, ram_we, exp_ram_we);
            end
            checks++;
            if (ram_addr !== exp_ram_addr || ram_wdata !== exp_ram_wdata) begin
                errors++;
                $display("FAIL rnd_ram_bus @%0d: got %h/%h required %h/%h",
                         edge_n, ram_addr, ram_wdata, exp_ram_addr, exp_ram_wdata);
            end
            drive_reqs(35, 60);
        end
        drain();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            dev_mem[a]   = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
            model_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
        end
        edge_n     = 0;
        cpu_last   = -100;
        vdp_last   = -100;
        cpu_ack_at = -1;
        vdp_ack_at = -1;
        starve_m   = 0;
        reset      = 1'b1;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        vdp_req    = 1'b0;
        vdp_addr   = '0;
        @(negedge clk);

        test_reset();
        test_cpu_write_read();
        test_vdp_only();
        test_contention();
        test_simultaneous();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
